// File: rtl/imem_loader.sv
// -----------------------------------------------------------------------------
// imem_loader
//
// Boot-time program loader. Receives a byte stream consisting of a 16-bit
// little-endian word count N followed by N little-endian 32-bit instruction
// words, and writes each word into an instruction memory at consecutive
// word-aligned byte addresses starting at 0. The processor core is held in
// reset for the whole load and released once the load has completed.
//
// Ports
//   i_clk         rising-edge clock
//   i_rst         synchronous active-high reset
//   i_start       one-cycle request to begin a load (honoured in IDLE / DONE)
//   i_byte        incoming program byte
//   i_byte_valid  i_byte is valid
//   o_byte_ready  loader accepts a byte this cycle
//   o_we          instruction memory write strobe (one cycle per word)
//   o_waddr       word-aligned byte address of the write
//   o_wdata       instruction word to write
//   o_cpu_rst     holds the processor core in reset while high
//   o_done        load completed
//   o_err         declared word count exceeds memory capacity
//
// state  | meaning
// -------+----------------------------------------------------------------
// IDLE   | waiting for i_start after reset
// LEN_LO | expecting low byte of the word count
// LEN_HI | expecting high byte of the word count; range-checked on accept
// DATA   | assembling and writing instruction words
// DONE   | load finished (or rejected); core released, i_start reloads
// -----------------------------------------------------------------------------
module imem_loader #(
    parameter int P_DATA_WIDTH = 32,
    parameter int P_ADDR_WIDTH = 10
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_start,
    input  logic [7:0]              i_byte,
    input  logic                    i_byte_valid,
    output logic                    o_byte_ready,
    output logic                    o_we,
    output logic [P_ADDR_WIDTH-1:0] o_waddr,
    output logic [P_DATA_WIDTH-1:0] o_wdata,
    output logic                    o_cpu_rst,
    output logic                    o_done,
    output logic                    o_err
);

    // Word index needs to address 2^(P_ADDR_WIDTH-2) words; the remaining-word
    // counter needs one more bit because it must hold the full capacity.
    localparam int          IDX_W     = P_ADDR_WIDTH - 2;
    localparam int          CNT_W     = P_ADDR_WIDTH - 1;
    localparam int unsigned CAP_WORDS = 2 ** IDX_W;

    typedef enum logic [2:0] {
        IDLE,
        LEN_LO,
        LEN_HI,
        DATA,
        DONE
    } state_t;

    state_t                  state;
    logic [7:0]              len_lo;
    logic [15:0]             len_word;
    logic [1:0]              byte_cnt;
    logic [IDX_W-1:0]        word_idx;
    logic [CNT_W-1:0]        words_left;
    // Holds the first three bytes of the current word; each new byte enters
    // at the top so after three bytes the oldest sits in bits 7:0.
    logic [P_DATA_WIDTH-9:0] shift;
    logic                    accept;

    assign accept   = i_byte_valid && o_byte_ready;
    assign len_word = {i_byte, len_lo};

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state        <= IDLE;
            len_lo       <= '0;
            byte_cnt     <= '0;
            word_idx     <= '0;
            words_left   <= '0;
            shift        <= '0;
            o_byte_ready <= 1'b0;
            o_we         <= 1'b0;
            o_waddr      <= '0;
            o_wdata      <= '0;
            o_cpu_rst    <= 1'b1;
            o_done       <= 1'b0;
            o_err        <= 1'b0;
        end else begin
            o_we <= 1'b0;

            case (state)
                IDLE: begin
                    if (i_start) begin
                        state        <= LEN_LO;
                        o_byte_ready <= 1'b1;
                        o_err        <= 1'b0;
                    end
                end

                LEN_LO: begin
                    if (accept) begin
                        len_lo <= i_byte;
                        state  <= LEN_HI;
                    end
                end

                LEN_HI: begin
                    if (accept) begin
                        if (len_word == 16'd0) begin
                            state        <= DONE;
                            o_byte_ready <= 1'b0;
                            o_done       <= 1'b1;
                            o_cpu_rst    <= 1'b0;
                        end else if (32'(len_word) > CAP_WORDS) begin
                            // Rejected before any write so the address can
                            // never wrap past the end of the memory.
                            state        <= DONE;
                            o_byte_ready <= 1'b0;
                            o_done       <= 1'b1;
                            o_cpu_rst    <= 1'b0;
                            o_err        <= 1'b1;
                        end else begin
                            state      <= DATA;
                            words_left <= CNT_W'(len_word);
                            word_idx   <= '0;
                            byte_cnt   <= '0;
                        end
                    end
                end

                DATA: begin
                    if (accept) begin
                        shift    <= {i_byte, shift[P_DATA_WIDTH-9:8]};
                        byte_cnt <= byte_cnt + 2'd1;
                        if (byte_cnt == 2'd3) begin
                            o_we       <= 1'b1;
                            o_wdata    <= {i_byte, shift};
                            o_waddr    <= {word_idx, 2'b00};
                            word_idx   <= word_idx + IDX_W'(1);
                            words_left <= words_left - CNT_W'(1);
                            // Stop taking bytes already during the final
                            // write cycle; nothing more belongs to this load.
                            if (words_left == CNT_W'(1)) begin
                                o_byte_ready <= 1'b0;
                            end
                        end
                    end else if (words_left == '0) begin
                        // Only reachable in the write cycle of the last word.
                        state     <= DONE;
                        o_done    <= 1'b1;
                        o_cpu_rst <= 1'b0;
                    end
                end

                DONE: begin
                    if (i_start) begin
                        state        <= LEN_LO;
                        o_byte_ready <= 1'b1;
                        o_done       <= 1'b0;
                        o_err        <= 1'b0;
                        o_cpu_rst    <= 1'b1;
                    end
                end

                default: begin
                    state        <= IDLE;
                    o_byte_ready <= 1'b0;
                    o_done       <= 1'b0;
                    o_cpu_rst    <= 1'b1;
                end
            endcase
        end
    end

endmodule
